pa_perips_uart_tx: RTL

UART transmit peripheral that produces the chip-level `txd` line, the serial stream the simulation UART monitor decodes. Bytes written by the core's peripheral bus are queued in a small FIFO. A bit-timing state machine then serialises them as 8N1 frames (1 start, 8 data LSB-first, 1 stop) at a programmable bit period. The block sits between the bus peripheral decoder and the `txd` pin of `pa_chip_top`.

---
 rtl/pa_perips_uart_tx_if.sv | 27 ++
 rtl/pa_perips_uart_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pa_perips_uart_tx_if.sv
// Byte-write port of the UART transmitter: write strobe and data in,
// FIFO status (full, empty, occupancy) back to the bus side.
interface pa_perips_uart_tx_if #(
    parameter int FIFO_DEPTH = 8
) ();
    logic                          wr_en_i;
    logic [7:0]                    wr_data_i;
    logic                          full_o;
    logic                          empty_o;
    logic [$clog2(FIFO_DEPTH):0]   count_o;

    modport master (
        output wr_en_i,
        output wr_data_i,
        input  full_o,
        input  empty_o,
        input  count_o
    );

    modport slave (
        input  wr_en_i,
        input  wr_data_i,
        output full_o,
        output empty_o,
        output count_o
    );
endinterface

// File: rtl/pa_perips_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser with a programmable
// bit period; txd and all status outputs come straight from flops.
module pa_perips_uart_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pa_perips_uart_tx_if.slave    wr_bus,
    input  logic [DIV_WIDTH-1:0]  div_i,
    output logic                  busy_o,
    output logic                  txd
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_TWO   = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO  = DIV_WIDTH'(0);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]     CNT_ZERO  = CNT_W'(0);
    localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ZERO  = PTR_W'(0);

    // FIFO storage and bookkeeping
    logic [7:0]           mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 full_r;
    logic                 empty_r;

    // Serialiser state
    logic [1:0]           state_r;
    logic [7:0]           shift_r;
    logic [DIV_WIDTH-1:0] div_q_r;
    logic [DIV_WIDTH-1:0] cyc_r;
    logic [2:0]           bit_idx_r;
    logic                 txd_r;
    logic                 busy_r;

    // Next-state values
    logic                 push_s;
    logic                 pop_s;
    logic                 bit_end_s;
    logic [DIV_WIDTH-1:0] div_eff_s;
    logic [1:0]           state_next_s;
    logic [7:0]           shift_next_s;
    logic [DIV_WIDTH-1:0] div_q_next_s;
    logic [DIV_WIDTH-1:0] cyc_next_s;
    logic [2:0]           bit_idx_next_s;
    logic                 txd_next_s;
    logic [CNT_W-1:0]     count_next_s;

    assign push_s    = wr_bus.wr_en_i & ~full_r;
    assign div_eff_s = (div_i < DIV_TWO) ? DIV_TWO : div_i;
    assign bit_end_s = (cyc_r == (div_q_r - DIV_ONE));

    // Frame sequencing: decides pops, bit advance and the next txd level
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        div_q_next_s   = div_q_r;
        cyc_next_s     = cyc_r;
        bit_idx_next_s = bit_idx_r;
        pop_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    pop_s          = 1'b1;
                    shift_next_s   = mem_r[rd_ptr_r];
                    div_q_next_s   = div_eff_s;
                    cyc_next_s     = DIV_ZERO;
                    bit_idx_next_s = 3'd0;
                    state_next_s   = ST_START;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cyc_next_s   = DIV_ZERO;
                    state_next_s = ST_DATA;
                end else begin
                    cyc_next_s   = cyc_r + DIV_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cyc_next_s   = DIV_ZERO;
                    shift_next_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_next_s = 3'd0;
                        state_next_s   = ST_STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cyc_next_s   = cyc_r + DIV_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    cyc_next_s = DIV_ZERO;
                    // Back-to-back: the next start bit follows the stop bit directly
                    if (!empty_r) begin
                        pop_s          = 1'b1;
                        shift_next_s   = mem_r[rd_ptr_r];
                        div_q_next_s   = div_eff_s;
                        bit_idx_next_s = 3'd0;
                        state_next_s   = ST_START;
                    end else begin
                        state_next_s   = ST_IDLE;
                    end
                end else begin
                    cyc_next_s = cyc_r + DIV_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // txd level implied by the state being entered
    always_comb begin
        txd_next_s = 1'b1;
        case (state_next_s)
            ST_START: txd_next_s = 1'b0;
            ST_DATA:  txd_next_s = shift_next_s[0];
            default:  txd_next_s = 1'b1;
        endcase
    end

    // Occupancy update; a full FIFO refuses writes even while popping
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO data array; contents need no reset since pointers gate validity
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_bus.wr_data_i;
        end
    end

    // FIFO pointers and registered status
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
            empty_r <= (count_next_s == CNT_ZERO);
        end
    end

    // Serialiser registers, including the txd and busy output flops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'h00;
            div_q_r   <= DIV_TWO;
            cyc_r     <= DIV_ZERO;
            bit_idx_r <= 3'd0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            div_q_r   <= div_q_next_s;
            cyc_r     <= cyc_next_s;
            bit_idx_r <= bit_idx_next_s;
            txd_r     <= txd_next_s;
            busy_r    <= (state_next_s != ST_IDLE);
        end
    end

    assign txd            = txd_r;
    assign busy_o         = busy_r;
    assign wr_bus.full_o  = full_r;
    assign wr_bus.empty_o = empty_r;
    assign wr_bus.count_o = count_r;

endmodule
